uart_shift_core: RTL and testbench
==================================

# uart_shift_core

Parametrised full-duplex soft UART, successor to the fixed 8N1 shift-register TX/RX pair. One shared baud/oversample tick generator drives a transmit shifter and a 16x-oversampled receive shifter. Data width, parity mode, stop-bit count and baud divisor are configurable, and the receiver reports parity and framing errors. The block sits between a byte-level host interface and the serial pins; tx_line may be looped back to rx_line for self-test.

## Interface
- CLK_DIV, 27: clk cycles per oversample tick (≥2); bit time = CLK_DIV*16 clk
- DATA_BITS, 8: payload bits per frame, 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- tx_start  in  1  request to send tx_data; accepted only when tx_busy=0
- tx_data  in  DATA_BITS  payload, sampled on the accepting edge
- tx_line  out  1  serial out, idle high
- tx_busy  out  1  high from the cycle after acceptance to the end of the last stop bit
- tx_done  out  1  one-clk pulse at the end of the last stop bit
- rx_line  in  1  serial in, asynchronous
- rx_data  out  DATA_BITS  last received payload, held until the next rx_done
- rx_done  out  1  one-clk pulse, frame complete
- rx_parity_err  out  1  valid with rx_done, held until the next rx_done; 0 when PARITY=0
- rx_frame_err  out  1  any stop bit sampled low; valid with rx_done, held

## Operation
- Reset values: tx_line=1; tx_busy, tx_done, rx_done and both error flags = 0; rx_data=0; both FSMs in IDLE; tick divider = 0.
- Tick: free-running counter 0..CLK_DIV-1 that emits a one-clk tick at wrap. Both FSMs advance only on ticks. Each bit lasts 16 ticks.
- TX FSM, IDLE→START→DATA→(PARITY)→STOP→IDLE:
  - Accept on tx_start&&!tx_busy; latch data into the shifter.
  - START drives 0 beginning at the next tick.
  - DATA shifts out LSB first, DATA_BITS bits.
  - PARITY bit = XOR of the data bits (even) or its complement (odd).
  - STOP drives 1 for STOP_BITS bits.
  - tx_start while busy is ignored and not queued.
- RX: 2-flop synchroniser on rx_line. RX FSM, IDLE→START→DATA→(PARITY)→STOP→IDLE.
  - IDLE: a sync'd falling edge resets the tick phase counter.
  - START: sample at tick 7. If high, treat as a glitch and return to IDLE with no outputs.
  - DATA/PARITY/STOP: sample each bit at tick 7 of the bit, shifting LSB first.
  - At the last stop sample: update rx_data and the error flags, pulse rx_done, enter IDLE. The line may already be low for the next start bit.
- Parity error: received parity bit ≠ computed parity.
- Framing error: any stop bit sampled 0. Data is still delivered.
- TX and RX are independent. Simultaneous tx_start and rx_done are legal.

## Timing
- TX latency: tx_busy rises 1 clk after acceptance. The start bit begins 1..CLK_DIV clk after acceptance, at tick alignment.
- TX frame duration: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*16*CLK_DIV clk.
- tx_done and the tx_busy fall occur in the same cycle.
- RX detection: 2 clk synchroniser delay. rx_done occurs mid-way through the last stop bit, about 8.5 ticks before the sender's stop bit ends.
- Back-to-back TX: a new tx_start is accepted in the cycle after tx_done.
- Reset mid-frame: all outputs return to reset values asynchronously. No partial rx_done is produced.

## Structure
- Package uart_shift_pkg holds the parity-mode constants (PAR_NONE/ODD/EVEN), the TX and RX state enums, and the oversample constant 16.
- One sub-module, uart_baud_gen (tick divider, CLK_DIV parameter), instanced once and shared.
- TX and RX FSMs live in the core.

## Test plan
Bench setup: CLK_DIV=4 (bit time 64 clk), tx_line looped to rx_line unless stated otherwise.
- 8N1 loopback: send 0xA5 → rx_data=0xA5, exactly one rx_done, no errors, tx_busy high for 640±4 clk.
- 8E1: send 0x07 → parity bit 1 observed on tx_line. Driving rx directly with the parity bit forced 0 → rx_parity_err=1, rx_data=0x07.
- 7O2: send 0x55 → frame is 11 bits, rx_data=0x55, no errors. Force the second stop bit low → rx_frame_err=1.
- Glitch rejection: 3-clk low pulse on idle rx_line → no rx_done, FSM back in IDLE.
- Busy handling: second tx_start (0x3C) while busy is ignored. Issuing it in the cycle after tx_done → received 0x3C.
- Reset mid-frame: drop rst during the DATA bits → tx_line=1 and tx_busy=0 immediately, no rx_done. After release, a send of 0xA5 still loops back correctly.

Source files
------------

// File: rtl/uart_shift_pkg.sv
// rtl/uart_shift_pkg.sv - parity modes, oversample constant and FSM state types for uart_shift_core
package uart_shift_pkg;

  localparam int PAR_NONE   = 0;
  localparam int PAR_ODD    = 1;
  localparam int PAR_EVEN   = 2;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // data_xor is the XOR of all payload bits; odd mode inverts it
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick divider shared by TX and RX
module uart_baud_gen #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_shift_core.sv
// rtl/uart_shift_core.sv - parametrised full-duplex UART: TX shifter and 16x-oversampled RX shifter
module uart_shift_core
  import uart_shift_pkg::*;
#(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam logic [3:0] PH_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] PH_MID    = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != PAR_NONE);

  logic tick;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  tx_state_t            tx_state;
  logic [3:0]           tx_ph, tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  // Accepted frames wait in IDLE with tx_busy set until the next tick aligns the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_ph    <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == TX_IDLE) begin
        if (!tx_busy) begin
          if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_shift <= tx_data;
            tx_par   <= parity_bit(^tx_data, PARITY);
          end
        end else if (tick) begin
          tx_state <= TX_START;
          tx_line  <= 1'b0;
          tx_ph    <= '0;
        end
      end else if (tick) begin
        if (tx_ph != PH_LAST) begin
          tx_ph <= tx_ph + 4'd1;
        end else begin
          tx_ph <= '0;
          case (tx_state)
            TX_START: begin
              tx_state <= TX_DATA;
              tx_line  <= tx_shift[0];
              tx_cnt   <= '0;
            end
            TX_DATA: begin
              if (tx_cnt == DATA_LAST) begin
                tx_cnt   <= '0;
                tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
                tx_line  <= HAS_PAR ? tx_par : 1'b1;
              end else begin
                tx_shift <= tx_shift >> 1;
                tx_line  <= tx_shift[1];
                tx_cnt   <= tx_cnt + 4'd1;
              end
            end
            TX_PARITY: begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
              tx_cnt   <= '0;
            end
            TX_STOP: begin
              if (tx_cnt == STOP_LAST) begin
                tx_state <= TX_IDLE;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
              end else begin
                tx_cnt <= tx_cnt + 4'd1;
              end
            end
            default: tx_state <= TX_IDLE;
          endcase
        end
      end
    end
  end

  logic                 rx_s1, rx_s2, rx_s3;
  rx_state_t            rx_state;
  logic [3:0]           rx_ph, rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit, rx_stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_line;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Each bit is sampled at phase 7 and the bit boundary is taken at phase 15
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_ph         <= '0;
      rx_cnt        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_stop_bad   <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (rx_s3 && !rx_s2) begin
          rx_state    <= RX_START;
          rx_ph       <= '0;
          rx_stop_bad <= 1'b0;
        end
      end else if (tick) begin
        rx_ph <= (rx_ph == PH_LAST) ? 4'd0 : rx_ph + 4'd1;
        if (rx_ph == PH_MID) begin
          case (rx_state)
            RX_START:  if (rx_s2) rx_state <= RX_IDLE;
            RX_DATA:   rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            RX_PARITY: rx_par_bit <= rx_s2;
            RX_STOP: begin
              if (rx_cnt == STOP_LAST) begin
                rx_state      <= RX_IDLE;
                rx_done       <= 1'b1;
                rx_data       <= rx_shift;
                rx_parity_err <= HAS_PAR && (rx_par_bit != parity_bit(^rx_shift, PARITY));
                rx_frame_err  <= rx_stop_bad || !rx_s2;
              end else if (!rx_s2) begin
                rx_stop_bad <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (rx_ph == PH_LAST) begin
          case (rx_state)
            RX_START: begin
              rx_state <= RX_DATA;
              rx_cnt   <= '0;
            end
            RX_DATA: begin
              if (rx_cnt == DATA_LAST) begin
                rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                rx_cnt   <= '0;
              end else begin
                rx_cnt <= rx_cnt + 4'd1;
              end
            end
            RX_PARITY: begin
              rx_state <= RX_STOP;
              rx_cnt   <= '0;
            end
            RX_STOP: rx_cnt <= rx_cnt + 4'd1;
            default: rx_state <= RX_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_shift_core.sv
// tb/tb_uart_shift_core.sv - self-checking bench for uart_shift_core (8N1 loopback with cycle model, 8E1 and 7O2 directed)
module tb_uart_shift_core;

  localparam int CD    = 4;
  localparam int BIT_T = 16 * CD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, loop_a = 1'b1, drv_a = 1'b1;
  logic [7:0] data_a  = '0;
  logic       line_a, busy_a, done_a, rxl_a, rxdone_a, perr_a, ferr_a;
  logic [7:0] rxd_a;
  assign rxl_a = loop_a ? line_a : drv_a;

  logic       start_b = 1'b0, loop_b = 1'b1, drv_b = 1'b1;
  logic [7:0] data_b  = '0;
  logic       line_b, busy_b, done_b, rxl_b, rxdone_b, perr_b, ferr_b;
  logic [7:0] rxd_b;
  assign rxl_b = loop_b ? line_b : drv_b;

  logic       start_c = 1'b0, loop_c = 1'b1, drv_c = 1'b1;
  logic [6:0] data_c  = '0;
  logic       line_c, busy_c, done_c, rxl_c, rxdone_c, perr_c, ferr_c;
  logic [6:0] rxd_c;
  assign rxl_c = loop_c ? line_c : drv_c;

  uart_shift_core #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a), .tx_line(line_a),
    .tx_busy(busy_a), .tx_done(done_a), .rx_line(rxl_a), .rx_data(rxd_a), .rx_done(rxdone_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a));

  uart_shift_core #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b), .tx_line(line_b),
    .tx_busy(busy_b), .tx_done(done_b), .rx_line(rxl_b), .rx_data(rxd_b), .rx_done(rxdone_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b));

  uart_shift_core #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_start(start_c), .tx_data(data_c), .tx_line(line_c),
    .tx_busy(busy_c), .tx_done(done_c), .rx_line(rxl_c), .rx_data(rxd_c), .rx_done(rxdone_c),
    .rx_parity_err(perr_c), .rx_frame_err(ferr_c));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference for instance A: the frame is a bit list placed on the first tick edge after acceptance.
  // Ticks fall on every CD-th clock edge counted from reset release.
  typedef struct { logic [7:0] data; int end_k; } exp_t;
  exp_t       sb[$];
  int         m_k = 0, m_s = 0, m_e = 0;
  logic       m_busy = 1'b0, m_done = 1'b0;
  logic [9:0] m_bits = '0;
  logic [7:0] m_rx = '0;

  always begin
    logic pre;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_k = 0; m_busy = 1'b0; m_done = 1'b0;
      sb.delete();
    end else begin
      pre    = m_busy;
      m_k    = m_k + 1;
      m_done = 1'b0;
      if (pre && m_k == m_e) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      if (!pre && start_a) begin
        m_busy = 1'b1;
        m_s    = (m_k / CD + 1) * CD;
        m_e    = m_s + 10 * BIT_T;
        m_bits = {1'b1, data_a, 1'b0};
        sb.push_back('{data_a, m_e});
      end
    end
  end

  always begin
    logic exp_line;
    exp_t e;
    @(negedge clk);
    exp_line = (m_busy && m_k >= m_s) ? m_bits[(m_k - m_s) / BIT_T] : 1'b1;
    chk("a_tx_line", line_a, exp_line);
    chk("a_tx_busy", busy_a, m_busy);
    chk("a_tx_done", done_a, m_done);
    if (!rst_n) m_rx = '0;
    if (rxdone_a) begin
      chk("a_rx_done_pending", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e    = sb.pop_front();
        m_rx = e.data;
        chk("a_rx_done_in_last_stop", int'(m_k >= e.end_k - BIT_T && m_k < e.end_k), 1);
      end
    end
    chk("a_rx_data", rxd_a, m_rx);
    chk("a_rx_parity_err", perr_a, 0);
    chk("a_rx_frame_err", ferr_a, 0);
  end

  int rxn_a = 0, rxn_b = 0, rxn_c = 0;
  always begin
    @(negedge clk);
    if (rxdone_a) rxn_a++;
    if (rxdone_b) rxn_b++;
    if (rxdone_c) rxn_c++;
  end

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic [8:0] d, input logic v);
    case (sel)
      0:       begin start_a = v; data_a = d[7:0]; end
      1:       begin start_b = v; data_b = d[7:0]; end
      default: begin start_c = v; data_c = d[6:0]; end
    endcase
  endtask

  task automatic set_drv(input int sel, input logic v);
    case (sel)
      0:       drv_a = v;
      1:       drv_b = v;
      default: drv_c = v;
    endcase
  endtask

  task automatic wait_done(input int sel, input int max);
    for (int i = 0; i < max; i++) begin
      if (done_of(sel)) return;
      @(negedge clk);
    end
    chk("tx_done_timeout", done_of(sel), 1);
  endtask

  task automatic send(input int sel, input logic [8:0] d, output int busy_cyc);
    @(negedge clk); set_start(sel, d, 1'b1);
    @(negedge clk); set_start(sel, d, 1'b0);
    busy_cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done_of(sel)) return;
      if (busy_of(sel)) busy_cyc++;
      @(negedge clk);
    end
    chk("send_timeout", done_of(sel), 1);
  endtask

  task automatic drive_frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); set_drv(sel, bits[i]);
      repeat (BIT_T - 1) @(negedge clk);
    end
    @(negedge clk); set_drv(sel, 1'b1);
  endtask

  initial begin
    int bc, n0;
    repeat (3) @(negedge clk);
    chk("rst_tx_line_a", line_a, 1);
    chk("rst_tx_busy_a", busy_a, 0);
    chk("rst_rx_data_a", rxd_a, 0);
    chk("rst_rx_done_a", rxdone_a, 0);
    chk("rst_tx_line_c", line_c, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 loopback
    send(0, 9'h0A5, bc);
    chk("a5_busy_640pm4", int'(bc >= 636 && bc <= 644), 1);
    repeat (20) @(negedge clk);
    chk("a5_rx_data", rxd_a, 8'hA5);
    chk("a5_rx_count", rxn_a, 1);

    // glitch rejection
    n0 = rxn_a;
    loop_a = 1'b0;
    @(negedge clk); drv_a = 1'b0;
    repeat (3) @(negedge clk); drv_a = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_rx_done", rxn_a - n0, 0);
    loop_a = 1'b1;

    // busy handling and back-to-back
    n0 = rxn_a;
    @(negedge clk); start_a = 1'b1; data_a = 8'h11;
    @(negedge clk); start_a = 1'b0;
    repeat (100) @(negedge clk); start_a = 1'b1; data_a = 8'h3C;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, 2000);
    start_a = 1'b1; data_a = 8'h3C;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, 2000);
    repeat (20) @(negedge clk);
    chk("b2b_rx_data", rxd_a, 8'h3C);
    chk("b2b_rx_count", rxn_a - n0, 2);

    // reset during the data bits
    n0 = rxn_a;
    @(negedge clk); start_a = 1'b1; data_a = 8'hF0;
    @(negedge clk); start_a = 1'b0;
    repeat (4 * BIT_T) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_tx_line", line_a, 1);
    chk("midrst_tx_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("midrst_no_rx_done", rxn_a - n0, 0);
    send(0, 9'h0A5, bc);
    repeat (20) @(negedge clk);
    chk("post_rst_rx_data", rxd_a, 8'hA5);
    chk("post_rst_rx_count", rxn_a - n0, 1);

    // 8E1
    n0 = rxn_b;
    @(negedge clk); start_b = 1'b1; data_b = 8'h07;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 10 && line_b; i++) @(negedge clk);
    chk("8e1_start_bit", line_b, 0);
    repeat (9 * BIT_T + BIT_T / 2) @(negedge clk);
    chk("8e1_parity_bit_on_line", line_b, 1);
    wait_done(1, 2000);
    repeat (20) @(negedge clk);
    chk("8e1_rx_data", rxd_b, 8'h07);
    chk("8e1_parity_err_clean", perr_b, 0);
    chk("8e1_frame_err_clean", ferr_b, 0);
    loop_b = 1'b0;
    drive_frame(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge clk);
    chk("8e1_forced_parity_err", perr_b, 1);
    chk("8e1_forced_rx_data", rxd_b, 8'h07);
    chk("8e1_forced_frame_err", ferr_b, 0);
    chk("8e1_rx_count", rxn_b - n0, 2);

    // 7O2
    n0 = rxn_c;
    send(2, 9'h055, bc);
    chk("7o2_busy_11_bits", int'(bc >= 700 && bc <= 708), 1);
    repeat (20) @(negedge clk);
    chk("7o2_rx_data", rxd_c, 7'h55);
    chk("7o2_parity_err_clean", perr_c, 0);
    chk("7o2_frame_err_clean", ferr_c, 0);
    loop_c = 1'b0;
    drive_frame(2, {5'b0, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
    repeat (20) @(negedge clk);
    chk("7o2_stop2_frame_err", ferr_c, 1);
    chk("7o2_stop2_parity_err", perr_c, 0);
    chk("7o2_stop2_rx_data", rxd_c, 7'h55);
    chk("7o2_rx_count", rxn_c - n0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
